// File: rtl/serial_frame_tx.sv
// Parallel-to-serial framer: start bit, LSB-first data, optional parity, stop bit.
// The line idles high and serial_out always comes straight from a flop.
module serial_frame_tx #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int BIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              serial_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST_CYCLE = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_serial;
  logic              w_next_serial;
  logic [DATA_W-1:0] r_shift;
  logic              r_parity;
  logic [BW-1:0]     r_bit;
  logic [CW-1:0]     r_cycle;
  logic              w_accept;
  logic              w_bit_end;
  logic              w_load;
  logic              w_shift;

  assign din_ready  = (r_state == IDLE);
  assign w_accept   = din_valid && din_ready;
  assign w_bit_end  = (r_cycle == LAST_CYCLE);
  assign busy       = (r_state != IDLE);
  assign frame_done = (r_state == STOP) && w_bit_end;
  assign serial_out = r_serial;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_serial <= 1'b1;
    end else begin
      r_state  <= w_next_state;
      r_serial <= w_next_serial;
    end
  end

  // The line value for the upcoming bit is decided here and registered with the state,
  // so serial_out changes exactly when the state does.
  always_comb begin
    w_next_state  = r_state;
    w_next_serial = r_serial;
    w_load        = 1'b0;
    w_shift       = 1'b0;
    case (r_state)
      IDLE: begin
        w_next_serial = 1'b1;
        if (w_accept) begin
          w_next_state  = START;
          w_next_serial = 1'b0;
          w_load        = 1'b1;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_next_state  = DATA;
          w_next_serial = r_shift[0];
          w_shift       = 1'b1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_bit == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              w_next_state  = PARITY;
              w_next_serial = r_parity;
            end else begin
              w_next_state  = STOP;
              w_next_serial = 1'b1;
            end
          end else begin
            w_next_serial = r_shift[0];
            w_shift       = 1'b1;
          end
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_next_state  = STOP;
          w_next_serial = 1'b1;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_next_state  = IDLE;
          w_next_serial = 1'b1;
        end
      end
      default: begin
        w_next_state  = IDLE;
        w_next_serial = 1'b1;
      end
    endcase
  end

  // r_shift[0] always holds the next data bit still to be put on the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_bit    <= '0;
      r_cycle  <= '0;
    end else begin
      if (w_load) begin
        r_shift  <= din;
        r_parity <= (^din) ^ (PARITY_ODD != 0);
        r_bit    <= '0;
      end else if (w_shift) begin
        r_shift <= r_shift >> 1;
        if (r_state == DATA) begin
          r_bit <= r_bit + BW'(1);
        end
      end
      if (r_state == IDLE || w_bit_end) begin
        r_cycle <= '0;
      end else begin
        r_cycle <= r_cycle + CW'(1);
      end
    end
  end

endmodule
